// File: rtl/des_iter_engine_if.sv
// Streaming bundle for the DES/3DES engine.
// Upstream block/key/mode channel plus the downstream result channel.
interface des_iter_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] key1;
    logic [63:0] key2;
    logic [63:0] key3;
    logic        decrypt;
    logic        tdes;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport master (
        output in_valid, in_data, key1, key2, key3,
        output decrypt, tdes, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, key1, key2, key3,
        input  decrypt, tdes, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/des_iter_engine.sv
// Iterative DES / 3DES-EDE core, ROUNDS_PER_CYCLE Feistel rounds per clock.
// Key schedule is held in C/D registers and rotated in either direction.
module des_iter_engine #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int TDES_EN          = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    des_iter_engine_if.slave  bus,
    output logic              busy
);

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int SBOX [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    // bit j set = round j+1 shifts by two
    localparam logic [15:0] SHIFT2 = 16'h7EFC;
    localparam logic [3:0]  STEP   = 4'(ROUNDS_PER_CYCLE);
    localparam logic [3:0]  LAST   = 4'(16 - ROUNDS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    function automatic logic [63:0] ip_f(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] k);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = k[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] cd);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = cd[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] f_f(
        input logic [31:0] r,
        input logic [47:0] k
    );
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        int          idx;
        x = '0;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            b   = x[47-6*i -: 6];
            idx = i * 64 + 32 * int'(b[5]) + 16 * int'(b[0])
                + int'(b[4:1]);
            s[31-4*i -: 4] = 4'(SBOX[idx]);
        end
        y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

    function automatic logic [27:0] rol_f(input logic [27:0] x,
                                          input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror_f(input logic [27:0] x,
                                          input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // EDE order: encrypt K1,K2,K3; decrypt K3,K2,K1
    function automatic logic [63:0] key_f(
        input logic [1:0]  p,
        input logic        dec,
        input logic        td,
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [63:0] c
    );
        if (p == 2'd1)      return b;
        else if (p == 2'd0) return (dec && td) ? c : a;
        else                return dec ? a : c;
    endfunction

    state_t      state_q;
    logic        rdy_q;
    logic        ov_q;
    logic [63:0] od_q;
    logic        busy_q;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  rnd_q;
    logic [1:0]  pass_q;
    logic [63:0] k1_q, k2_q, k3_q;
    logic        dec_q, tdes_q;

    logic        dir;
    logic        tdes_in;
    logic [1:0]  last_pass;
    logic [63:0] ip_in;
    logic [31:0] nl, nr;
    logic [27:0] nc, nd;

    assign dir       = dec_q ^ (pass_q == 2'd1);
    assign tdes_in   = bus.tdes && (TDES_EN != 0);
    assign last_pass = tdes_q ? 2'd2 : 2'd0;
    assign ip_in     = ip_f(bus.in_data);

    always_comb begin
        logic [3:0]  j;
        logic [3:0]  jr;
        logic [31:0] t;
        nl = l_q;
        nr = r_q;
        nc = c_q;
        nd = d_q;
        j  = '0;
        jr = '0;
        t  = '0;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            j = rnd_q + 4'(k);
            if (!dir) begin
                nc = rol_f(nc, SHIFT2[j]);
                nd = rol_f(nd, SHIFT2[j]);
            end else if (j != 4'd0) begin
                jr = 4'd0 - j;
                nc = ror_f(nc, SHIFT2[jr]);
                nd = ror_f(nd, SHIFT2[jr]);
            end
            t  = nl ^ f_f(nr, pc2_f({nc, nd}));
            nl = nr;
            nr = t;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            ov_q    <= 1'b0;
            od_q    <= '0;
            busy_q  <= 1'b0;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            rnd_q   <= '0;
            pass_q  <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
            dec_q   <= 1'b0;
            tdes_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        l_q        <= ip_in[63:32];
                        r_q        <= ip_in[31:0];
                        {c_q, d_q} <= pc1_f(key_f(2'd0, bus.decrypt,
                                        tdes_in, bus.key1,
                                        bus.key2, bus.key3));
                        k1_q    <= bus.key1;
                        k2_q    <= bus.key2;
                        k3_q    <= bus.key3;
                        dec_q   <= bus.decrypt;
                        tdes_q  <= tdes_in;
                        rnd_q   <= '0;
                        pass_q  <= '0;
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    rnd_q <= rnd_q + STEP;
                    if (rnd_q != LAST) begin
                        l_q <= nl;
                        r_q <= nr;
                        c_q <= nc;
                        d_q <= nd;
                    end else if (pass_q != last_pass) begin
                        // FP/IP cancel between passes: swapped halves go straight in
                        l_q        <= nr;
                        r_q        <= nl;
                        {c_q, d_q} <= pc1_f(key_f(pass_q + 2'd1,
                                        dec_q, tdes_q, k1_q, k2_q, k3_q));
                        pass_q     <= pass_q + 2'd1;
                    end else begin
                        od_q    <= fp_f({nr, nl});
                        ov_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        ov_q    <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_des_iter_engine.sv
// Directed bench: DES/3DES known-answer vectors on three engine configurations,
// plus output stall, back-to-back accept and mid-block reset.
module tb_des_iter_engine;

    localparam logic [63:0] KA = 64'h133457799BBCDFF1;
    localparam logic [63:0] KB = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PA = 64'h0123456789ABCDEF;
    localparam logic [63:0] CA = 64'h85E813540F0AB405;
    localparam logic [63:0] PB = 64'h8787878787878787;
    localparam logic [63:0] CB = 64'h0000000000000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [2:0]  v = '0;
    logic [2:0]  ordy = '0;
    logic [63:0] din = '0, k1 = '0, k2 = '0, k3 = '0;
    logic        dec = 1'b0, td = 1'b0;
    logic        busy1, busy4, busy16;

    des_iter_engine_if b1 ();
    des_iter_engine_if b4 ();
    des_iter_engine_if b16 ();

    assign b1.in_valid  = v[0];
    assign b4.in_valid  = v[1];
    assign b16.in_valid = v[2];
    assign b1.out_ready  = ordy[0];
    assign b4.out_ready  = ordy[1];
    assign b16.out_ready = ordy[2];
    assign b1.in_data  = din;
    assign b4.in_data  = din;
    assign b16.in_data = din;
    assign b1.key1  = k1;
    assign b4.key1  = k1;
    assign b16.key1 = k1;
    assign b1.key2  = k2;
    assign b4.key2  = k2;
    assign b16.key2 = k2;
    assign b1.key3  = k3;
    assign b4.key3  = k3;
    assign b16.key3 = k3;
    assign b1.decrypt  = dec;
    assign b4.decrypt  = dec;
    assign b16.decrypt = dec;
    assign b1.tdes  = td;
    assign b4.tdes  = td;
    assign b16.tdes = td;

    des_iter_engine #(.ROUNDS_PER_CYCLE(1), .TDES_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .busy(busy1));
    des_iter_engine #(.ROUNDS_PER_CYCLE(4), .TDES_EN(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4), .busy(busy4));
    des_iter_engine #(.ROUNDS_PER_CYCLE(16), .TDES_EN(0)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(b16), .busy(busy16));

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // runs one block on all three engines; c16 = dut16 result is known
    task automatic xfer(input string tag, input logic [63:0] d,
                        input logic [63:0] a1, input logic [63:0] a2,
                        input logic [63:0] a3, input logic dc,
                        input logic t, input logic [63:0] exp,
                        input int lat1, input int lat4, input bit c16);
        int          lat [3];
        logic [63:0] got [3];
        lat = '{0, 0, 0};
        got = '{64'h0, 64'h0, 64'h0};
        @(negedge clk);
        din = d; k1 = a1; k2 = a2; k3 = a3; dec = dc; td = t;
        v = 3'b111;
        @(posedge clk);
        @(negedge clk);
        v = 3'b000;
        din = ~d; k1 = ~a1; k2 = ~a2; k3 = ~a3; dec = ~dc; td = ~t;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (b1.out_valid && lat[0] == 0) begin
                lat[0] = n; got[0] = b1.out_data;
            end
            if (b4.out_valid && lat[1] == 0) begin
                lat[1] = n; got[1] = b4.out_data;
            end
            if (b16.out_valid && lat[2] == 0) begin
                lat[2] = n; got[2] = b16.out_data;
            end
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
        end
        chk({tag, "_data1"}, got[0], exp);
        chk({tag, "_lat1"}, 64'(lat[0]), 64'(lat1));
        chk({tag, "_data4"}, got[1], exp);
        chk({tag, "_lat4"}, 64'(lat[1]), 64'(lat4));
        if (c16) chk({tag, "_data16"}, got[2], exp);
        chk({tag, "_lat16"}, 64'(lat[2]), 64'd1);
        ordy = 3'b111;
        @(posedge clk);
        @(negedge clk);
        ordy = 3'b000;
        chk({tag, "_ovalid_clr"}, 64'(b1.out_valid), 64'd0);
        chk({tag, "_iready_set"}, 64'(b1.in_ready), 64'd1);
    endtask

    initial begin
        int  n;
        bit  seen;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(b1.in_ready), 64'd1);
        chk("rst_out_valid", 64'(b1.out_valid), 64'd0);
        chk("rst_out_data", b1.out_data, 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        rst_n = 1'b1;

        xfer("des_enc_a", PA, KA, KB, KB, 1'b0, 1'b0, CA, 16, 4, 1'b1);
        xfer("des_dec_a", CA, KA, KB, KB, 1'b1, 1'b0, PA, 16, 4, 1'b1);
        xfer("des_enc_b", PB, KB, KA, KA, 1'b0, 1'b0, CB, 16, 4, 1'b1);
        xfer("des_dec_b", CB, KB, KA, KA, 1'b1, 1'b0, PB, 16, 4, 1'b1);
        xfer("tdes_enc_eq", PA, KA, KA, KA, 1'b0, 1'b1, CA, 48, 12, 1'b1);
        xfer("tdes_dec_eq", CA, KA, KA, KA, 1'b1, 1'b1, PA, 48, 12, 1'b1);
        xfer("tdes_enc_k1", PA, KA, KB, KB, 1'b0, 1'b1, CA, 48, 12, 1'b1);
        xfer("tdes_dec_k1", CA, KA, KB, KB, 1'b1, 1'b1, PA, 48, 12, 1'b1);
        xfer("tdes_enc_k3", PA, KB, KB, KA, 1'b0, 1'b1, CA, 48, 12, 1'b0);
        xfer("tdes_dec_k3", CB, KA, KA, KB, 1'b1, 1'b1, PB, 48, 12, 1'b0);

        // output stall with a second block pending on the input
        @(negedge clk);
        din = PA; k1 = KA; k2 = KA; k3 = KA; dec = 1'b0; td = 1'b0;
        v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din = PB; k1 = KB;
        n = 0;
        while (!b1.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("stall_lat", 64'(n), 64'd16);
        chk("stall_data", b1.out_data, CA);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold_data", b1.out_data, CA);
            chk("stall_hold_valid", 64'(b1.out_valid), 64'd1);
            chk("stall_in_ready", 64'(b1.in_ready), 64'd0);
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("gap_out_valid", 64'(b1.out_valid), 64'd0);
        chk("gap_in_ready", 64'(b1.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        v[0] = 1'b0;
        chk("b2b_busy", 64'(busy1), 64'd1);
        chk("b2b_in_ready", 64'(b1.in_ready), 64'd0);
        n = 0;
        while (!b1.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_lat", 64'(n), 64'd16);
        chk("b2b_data", b1.out_data, CB);
        @(posedge clk);
        @(negedge clk);
        ordy[0] = 1'b0;
        chk("b2b_done", 64'(b1.out_valid), 64'd0);

        // reset in the middle of a block
        @(negedge clk);
        din = PA; k1 = KA; dec = 1'b0; td = 1'b0;
        v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v[0] = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(b1.out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(b1.in_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy1), 64'd0);
        chk("mid_rst_out_data", b1.out_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (b1.out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_out", 64'(seen), 64'd0);
        chk("mid_rst_ready", 64'(b1.in_ready), 64'd1);
        xfer("post_rst", PA, KA, KB, KB, 1'b0, 1'b0, CA, 16, 4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
